// File: rtl/branch_control_unit.sv
// Hardwired Moore sequencer for fetch/decode/execute of br, jr, jal, nop and halt.
// Optional performance counters are enabled by defining BCU_PERF_COUNT_EN.
module branch_control_unit #(
   parameter logic [4:0] OP_BR   = 5'b10010,
   parameter logic [4:0] OP_JR   = 5'b10011,
   parameter logic [4:0] OP_JAL  = 5'b10100,
   parameter logic [4:0] OP_NOP  = 5'b11001,
   parameter logic [4:0] OP_HALT = 5'b11010
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] IR,
   input  logic        con_ff,
   output logic        PCout,
   output logic        MARin,
   output logic        IncPC,
   output logic        Read,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Gra,
   output logic        Grb,
   output logic        Rout,
   output logic        Rin,
   output logic        BAout,
   output logic        CONin,
   output logic        Yin,
   output logic        Cout,
   output logic        BRANCH,
   output logic        Zin,
   output logic        Zlowout,
   output logic        PCin,
   output logic        LinkSel,
   output logic        Run,
   output logic        Illegal
`ifdef BCU_PERF_COUNT_EN
   ,
   output logic [15:0] br_taken_cnt,
   output logic [15:0] br_nottaken_cnt,
   output logic [15:0] instr_cnt
`endif
);

   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_T0   = 4'd1;
   localparam logic [3:0] S_T1   = 4'd2;
   localparam logic [3:0] S_T2   = 4'd3;
   localparam logic [3:0] S_T3   = 4'd4;
   localparam logic [3:0] S_BR3  = 4'd5;
   localparam logic [3:0] S_BR4  = 4'd6;
   localparam logic [3:0] S_BR5  = 4'd7;
   localparam logic [3:0] S_BR6  = 4'd8;
   localparam logic [3:0] S_J3   = 4'd9;
   localparam logic [3:0] S_L3   = 4'd10;
   localparam logic [3:0] S_L4   = 4'd11;
   localparam logic [3:0] S_HALT = 4'd12;

   logic [3:0] state;
   logic [3:0] next_state;
   logic       br_flag;
   logic       illegal_q;
   logic [4:0] opcode;
   logic       ir_unused;

   assign opcode    = IR[31:27];
   assign ir_unused = ^IR[26:0];

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: next_state = S_T0;
         S_T0:   next_state = S_T1;
         S_T1:   next_state = S_T2;
         S_T2:   next_state = S_T3;
         S_T3: begin
            if (opcode == OP_BR)        next_state = S_BR3;
            else if (opcode == OP_JR)   next_state = S_J3;
            else if (opcode == OP_JAL)  next_state = S_L3;
            else if (opcode == OP_NOP)  next_state = S_T0;
            else                        next_state = S_HALT;
         end
         S_BR3:  next_state = S_BR4;
         S_BR4:  next_state = S_BR5;
         S_BR5:  next_state = br_flag ? S_BR6 : S_T0;
         S_BR6:  next_state = S_T0;
         S_J3:   next_state = S_T0;
         S_L3:   next_state = S_L4;
         S_L4:   next_state = S_T0;
         S_HALT: next_state = S_HALT;
         default: next_state = S_IDLE;
      endcase
   end

   // Condition is captured leaving BR4, one cycle after CONin loaded the CON FF.
   always_ff @(posedge clk) begin
      if (!clr) begin
         state     <= S_IDLE;
         br_flag   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state <= next_state;
         if (state == S_T0)
            br_flag <= 1'b0;
         else if (state == S_BR4)
            br_flag <= con_ff;
         if (state == S_T3 && opcode != OP_BR && opcode != OP_JR && opcode != OP_JAL &&
             opcode != OP_NOP && opcode != OP_HALT)
            illegal_q <= 1'b1;
      end
   end

   assign Illegal = illegal_q;

   always_comb begin
      PCout   = 1'b0;
      MARin   = 1'b0;
      IncPC   = 1'b0;
      Read    = 1'b0;
      MDRin   = 1'b0;
      MDRout  = 1'b0;
      IRin    = 1'b0;
      Gra     = 1'b0;
      Grb     = 1'b0;
      Rout    = 1'b0;
      Rin     = 1'b0;
      BAout   = 1'b0;
      CONin   = 1'b0;
      Yin     = 1'b0;
      Cout    = 1'b0;
      BRANCH  = 1'b0;
      Zin     = 1'b0;
      Zlowout = 1'b0;
      PCin    = 1'b0;
      LinkSel = 1'b0;
      Run     = (state != S_IDLE) && (state != S_HALT);
      case (state)
         S_T0: begin
            PCout = 1'b1;
            MARin = 1'b1;
         end
         S_T1: begin
            IncPC = 1'b1;
            Read  = 1'b1;
            MDRin = 1'b1;
         end
         S_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         S_BR3: begin
            Gra   = 1'b1;
            Rout  = 1'b1;
            CONin = 1'b1;
         end
         S_BR4: begin
            PCout = 1'b1;
            Yin   = 1'b1;
         end
         S_BR5: begin
            Cout   = 1'b1;
            BRANCH = 1'b1;
            Zin    = 1'b1;
         end
         S_BR6: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
         end
         S_J3, S_L4: begin
            Gra  = 1'b1;
            Rout = 1'b1;
            PCin = 1'b1;
         end
         S_L3: begin
            PCout   = 1'b1;
            Rin     = 1'b1;
            LinkSel = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef BCU_PERF_COUNT_EN
   always_ff @(posedge clk) begin
      if (!clr) begin
         br_taken_cnt    <= '0;
         br_nottaken_cnt <= '0;
         instr_cnt       <= '0;
      end else begin
         if (state == S_BR5 && next_state == S_BR6)
            br_taken_cnt <= br_taken_cnt + 16'd1;
         if (state == S_BR5 && next_state == S_T0)
            br_nottaken_cnt <= br_nottaken_cnt + 16'd1;
         if (state == S_T2)
            instr_cnt <= instr_cnt + 16'd1;
      end
   end
`endif

   a_one_bus_driver: assert property (@(posedge clk)
      $countones({PCout, MDRout, Rout, Zlowout, Cout}) <= 1);
   a_pcin_incpc_excl: assert property (@(posedge clk) !(PCin && IncPC));

endmodule
